levmarq_dot_acc: RTL
====================

// Module: levmarq_dot_acc
// PURPOSE
//  Streaming signed dot-product accumulator for the levmarq datapath; computes sum(a[i]*b[i]) over cfg_len element pairs.
//  It sits directly downstream of the 7x7 signed product stage (instantiated inside as the sub-module) and feeds the
//  Jacobian/normal-equation update logic. Valid/ready handshake on input and output. Result saturates with a sticky overflow flag.
// PARAMETERS
//  IN_WIDTH    7   signed width of each operand a, b
//  PROD_WIDTH  14  full signed product width (2*IN_WIDTH)
//  ACC_WIDTH   20  signed accumulator/result width (>= PROD_WIDTH)
//  LEN_WIDTH   8   width of element count; max vector length 2^LEN_WIDTH-1
// PORTS
//  ap_clk     in   1           clock, all state rising-edge
//  ap_rst_n   in   1           asynchronous active-low reset
//  start      in   1           1-cycle pulse; latches cfg_len, begins a vector; ignored unless FSM in IDLE
//  cfg_len    in   LEN_WIDTH   number of element pairs in the vector (0 allowed)
//  busy       out  1           high from accepted start until result handshake completes
//  in_a       in   IN_WIDTH    signed operand a
//  in_b       in   IN_WIDTH    signed operand b
//  in_valid   in   1           operand pair valid
//  in_ready   out  1           block can accept a pair this cycle
//  out_sum    out  ACC_WIDTH   signed dot product, saturated
//  out_ovf    out  1           saturation occurred during this vector
//  out_valid  out  1           result valid; held with data stable until out_ready
//  out_ready  in   1           downstream accepts result
// BEHAVIOUR
//  Reset (ap_rst_n low, async): FSM=IDLE; busy, in_ready, out_valid, out_ovf = 0; out_sum, acc, count = 0; product-valid reg = 0.
//  FSM states: IDLE, ACC, FLUSH, DONE.
//   IDLE: in_ready=0. On start: remaining<=cfg_len, acc<=0, ovf<=0; go ACC (or DONE directly if cfg_len==0).
//   ACC:  in_ready=1. Pair accepted when in_valid&&in_ready; remaining decrements. The acceptance that makes remaining 0 -> FLUSH.
//   FLUSH: in_ready=0; one cycle for the last product to reach the accumulator; then DONE.
//   DONE: out_valid=1, out_sum/out_ovf stable; on out_ready -> IDLE, busy=0 the next cycle.
//  Pipeline: stage 1 registers the full signed product a*b (PROD_WIDTH) plus a valid bit; stage 2 adds the sign-extended
//   product into acc. Latency: last pair accepted in cycle t -> out_valid high in cycle t+2. Throughput 1 pair/cycle.
//  Arithmetic: the sum is computed at ACC_WIDTH+1 bits. If it exceeds the signed ACC_WIDTH range, acc is clamped to
//   +(2^(ACC_WIDTH-1)-1) or -2^(ACC_WIDTH-1) and ovf is set sticky for the vector. Later terms continue from the clamped value.
//  cfg_len==0: out_valid in cycle after start, out_sum=0, out_ovf=0.
//  start while busy: ignored, with no effect on the vector in progress.
//  in_valid while in_ready=0: pair is not consumed; upstream must hold it.
//  out_ready low: result held indefinitely; in_ready stays 0 (no overlap of vectors).
//  Reset asserted mid-vector: all state cleared immediately; partial result discarded; no out_valid after release until a new start.
// STRUCTURE
//  Shared package levmarq_pkg: FSM state enum type (IDLE/ACC/FLUSH/DONE); localparams for default IN/PROD/ACC widths;
//   function sat_add(acc, prod) returning {ovf, clamped sum}.
//  Sub-module levmarq_mul_sxs: combinational signed IN_WIDTH x IN_WIDTH -> PROD_WIDTH multiplier, instantiated once.
//   Its output is registered by this block in stage 1.
//  Top level holds the FSM, remaining-count register, product pipeline register, and saturating accumulator.
// TESTING
//  1 start cfg_len=3; pairs (2,3),(-4,5),(7,-1), in_valid every cycle, out_ready=1 -> out_sum=-21, out_ovf=0, out_valid 2 cycles after 3rd accept.
//  2 start cfg_len=0 -> next cycle out_valid=1, out_sum=0, out_ovf=0; in_ready never asserted.
//  3 cfg_len=255, every pair (-64,-64)=4096, ACC_WIDTH=20 -> clamps at 524287 after the 128th product; out_sum=524287, out_ovf=1.
//  4 cfg_len=4, in_valid toggling 1,0,1,0,... and out_ready held 0 for 5 cycles -> sum correct; out_sum stable while waiting; second start pulses during busy ignored.
//  5 cfg_len=6, assert ap_rst_n=0 after 3 accepts, release, start cfg_len=1 with (1,1) -> single result out_sum=1; no stale result emitted.
//  6 back-to-back vectors: cfg_len=2 (3,3),(3,3) then start right after handshake, cfg_len=1 (-1,1) -> results 18 then -1; ovf cleared between vectors.

Source files
------------

// File: rtl/levmarq_pkg.sv
// levmarq_pkg: shared types, default widths and the saturating-add helper
// used by the levmarq dot-product accumulator.
package levmarq_pkg;

    // Default datapath widths for the dot-product accumulator.
    localparam int DEF_IN_WIDTH   = 7;
    localparam int DEF_PROD_WIDTH = 14;
    localparam int DEF_ACC_WIDTH  = 20;
    localparam int DEF_LEN_WIDTH  = 8;

    // Vector sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Adds a sign-extended product to the accumulator one bit wider than the
    // accumulator, then clamps back into the signed ACC range.
    // Returns {ovf, clamped_sum}. ovf is set only when clamping happened.
    function automatic logic [DEF_ACC_WIDTH:0] sat_add(
        input logic [DEF_ACC_WIDTH-1:0]  acc,
        input logic [DEF_PROD_WIDTH-1:0] prod
    );
        logic [DEF_ACC_WIDTH:0] wide;
        logic [DEF_ACC_WIDTH:0] res;
        wide = {acc[DEF_ACC_WIDTH-1], acc}
             + {{(DEF_ACC_WIDTH + 1 - DEF_PROD_WIDTH){prod[DEF_PROD_WIDTH-1]}}, prod};
        // The top two bits disagree only when the true sum left the range.
        if (wide[DEF_ACC_WIDTH] != wide[DEF_ACC_WIDTH-1]) begin
            if (wide[DEF_ACC_WIDTH]) begin
                // Negative overflow: clamp to the most negative value.
                res = {1'b1, 1'b1, {(DEF_ACC_WIDTH-1){1'b0}}};
            end else begin
                // Positive overflow: clamp to the most positive value.
                res = {1'b1, 1'b0, {(DEF_ACC_WIDTH-1){1'b1}}};
            end
        end else begin
            res = {1'b0, wide[DEF_ACC_WIDTH-1:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/levmarq_mul_sxs.sv
// levmarq_mul_sxs: combinational signed IN_WIDTH x IN_WIDTH multiplier with
// a full-width signed product. The caller registers the result.
module levmarq_mul_sxs
    import levmarq_pkg::*;
#(
    parameter int IN_WIDTH   = DEF_IN_WIDTH,
    parameter int PROD_WIDTH = DEF_PROD_WIDTH
) (
    input  logic [IN_WIDTH-1:0]   a,
    input  logic [IN_WIDTH-1:0]   b,
    output logic [PROD_WIDTH-1:0] p
);

    logic signed [PROD_WIDTH-1:0] p_s;

    // Both operands are sign-extended to the product width by the signed
    // context, so the product is exact (no truncation at 2*IN_WIDTH).
    always_comb begin
        p_s = $signed(a) * $signed(b);
        p   = p_s;
    end

endmodule

// File: rtl/levmarq_dot_acc.sv
// levmarq_dot_acc: streaming signed dot-product accumulator.
// Computes sum(a[i]*b[i]) over cfg_len pairs with a two-stage pipeline
// (registered product, then saturating accumulate) and returns the result
// over a valid/ready output with a sticky saturation flag.
//
// Handshake rules (both sides): a transfer happens on the rising edge where
// valid && ready are both high. The sender holds data stable while valid is
// high and ready is low; ready never depends combinationally on valid.
// Here in_ready and out_valid are registered, in_ready is high only in ACC,
// and out_valid is high only in DONE, so a new vector cannot overlap a
// result still waiting for out_ready.
module levmarq_dot_acc
    import levmarq_pkg::*;
#(
    parameter int IN_WIDTH   = DEF_IN_WIDTH,
    parameter int PROD_WIDTH = DEF_PROD_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] cfg_len,
    output logic                 busy,
    input  logic [IN_WIDTH-1:0]  in_a,
    input  logic [IN_WIDTH-1:0]  in_b,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic                 out_ovf,
    output logic                 out_valid,
    input  logic                 out_ready
);

    // Sequencer state, kept as a named typed signal for checkers to bind to.
    state_t                 state;
    logic [LEN_WIDTH-1:0]   remaining;

    // Stage 1: registered product and its valid bit.
    logic [PROD_WIDTH-1:0]  mul_p;
    logic [PROD_WIDTH-1:0]  prod_q;
    logic                   prod_vld;

    // Stage 2: saturating accumulator and sticky overflow.
    logic [ACC_WIDTH-1:0]   acc;
    logic                   ovf;
    logic [ACC_WIDTH:0]     sum_sat;

    logic                   accept;
    logic                   start_ok;

    assign accept   = in_valid && in_ready;
    assign start_ok = start && (state == ST_IDLE);

    levmarq_mul_sxs #(
        .IN_WIDTH   (IN_WIDTH),
        .PROD_WIDTH (PROD_WIDTH)
    ) u_mul (
        .a (in_a),
        .b (in_b),
        .p (mul_p)
    );

    // Sequencer: start latching, pair counting, flush slot and result hold.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state     <= ST_IDLE;
            remaining <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        remaining <= cfg_len;
                        busy      <= 1'b1;
                        if (cfg_len == '0) begin
                            // Empty vector: nothing to accumulate, report 0.
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state    <= ST_ACC;
                            in_ready <= 1'b1;
                        end
                    end
                end
                ST_ACC: begin
                    if (accept) begin
                        remaining <= remaining - LEN_WIDTH'(1);
                        if (remaining == LEN_WIDTH'(1)) begin
                            // Last pair taken; stop accepting immediately.
                            state    <= ST_FLUSH;
                            in_ready <= 1'b0;
                        end
                    end
                end
                ST_FLUSH: begin
                    // Last product lands in acc on this edge.
                    state     <= ST_DONE;
                    out_valid <= 1'b1;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    remaining <= '0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1: capture the product of each accepted pair.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            prod_q   <= '0;
            prod_vld <= 1'b0;
        end else begin
            prod_vld <= accept;
            if (accept) begin
                prod_q <= mul_p;
            end
        end
    end

    // Saturating sum of the current accumulator and the staged product.
    always_comb begin
        sum_sat = sat_add(acc, prod_q);
    end

    // Stage 2: clear on an accepted start, otherwise fold in valid products.
    // Clamped values are kept, so later terms continue from the rail.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (start_ok) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (prod_vld) begin
            acc <= sum_sat[ACC_WIDTH-1:0];
            ovf <= ovf | sum_sat[ACC_WIDTH];
        end
    end

    // acc is frozen in DONE, so the result stays stable until out_ready.
    assign out_sum = acc;
    assign out_ovf = ovf;

endmodule
